// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU plus an iterative 32-step multiply/divide
// unit owning the architectural HI/LO registers.
module ex_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Rdata1,
    input  logic [31:0] Rdata2,
    input  logic [31:0] Ed32,
    output logic [31:0] Result,
    output logic        Stall,
    output logic        MdBusy
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09,
                           OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C,
                           OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
                           OP_LW    = 6'h23, OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03,
                           F_MFHI = 6'h10, F_MTHI  = 6'h11, F_MFLO = 6'h12,
                           F_MTLO = 6'h13, F_MULT  = 6'h18, F_MULTU = 6'h19,
                           F_DIV  = 6'h1A, F_DIVU  = 6'h1B, F_ADD  = 6'h20,
                           F_ADDU = 6'h21, F_SUB   = 6'h22, F_SUBU = 6'h23,
                           F_AND  = 6'h24, F_OR    = 6'h25, F_XOR  = 6'h26,
                           F_NOR  = 6'h27, F_SLT   = 6'h2A, F_SLTU = 6'h2B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t   state, state_next;
    logic [4:0]  cnt;
    logic [64:0] acc;
    logic [31:0] opb;
    logic        is_div, neg_q, neg_r, div_zero;
    logic [31:0] hi, lo;

    logic [5:0]  op, funct;
    logic [4:0]  shamt;
    logic [31:0] zimm;
    logic        rtype, is_md, md_signed, md_div, is_mthi, is_mtlo;

    assign op     = Ins[31:26];
    assign funct  = Ins[5:0];
    assign shamt  = Ins[10:6];
    assign zimm   = {16'h0, Ins[15:0]};
    assign rtype  = (op == OP_RTYPE);
    assign md_div    = (funct == F_DIV)  || (funct == F_DIVU);
    assign md_signed = (funct == F_MULT) || (funct == F_DIV);
    assign is_md     = rtype && (md_div || funct == F_MULT || funct == F_MULTU);
    assign is_mthi   = rtype && (funct == F_MTHI);
    assign is_mtlo   = rtype && (funct == F_MTLO);

    // Operands are latched as magnitudes; signs are re-applied on the last step.
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    assign sign_a = md_signed & Rdata1[31];
    assign sign_b = md_signed & Rdata2[31];
    assign mag_a  = sign_a ? -Rdata1 : Rdata1;
    assign mag_b  = sign_b ? -Rdata2 : Rdata2;

    // One iteration of shift-add (mul) or restoring shift-subtract (div).
    logic [32:0] mul_sum, div_sh, div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [64:0] mul_next, div_next, step;
    assign mul_sum  = acc[64:32] + {1'b0, opb};
    assign mul_next = acc[0] ? ({mul_sum, acc[31:0]} >> 1) : (acc >> 1);
    assign div_sh   = {acc[63:32], acc[31]};
    assign div_diff = div_sh - {1'b0, opb};
    assign div_ge   = (div_sh >= {1'b0, opb});
    assign div_rem  = div_ge ? div_diff[31:0] : div_sh[31:0];
    assign div_next = {1'b0, div_rem, acc[30:0], div_ge};
    assign step     = is_div ? div_next : mul_next;

    logic [63:0] prod_fix;
    logic [31:0] hi_fin, lo_fin;
    assign prod_fix = neg_q ? -step[63:0] : step[63:0];
    assign hi_fin = is_div ? (neg_r ? -step[63:32] : step[63:32]) : prod_fix[63:32];
    assign lo_fin = is_div ? (div_zero ? 32'hFFFF_FFFF : (neg_q ? -step[31:0] : step[31:0]))
                           : prod_fix[31:0];

    logic unused_bits;
    assign unused_bits = ^{Ins[25:16], div_diff[32]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        MdBusy     = (state != IDLE);
        case (state)
            IDLE: if (is_md) begin
                Stall      = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                Stall = 1'b1;
                if (cnt == 5'd31) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (RST) Stall = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_md) begin
                        acc      <= {33'h0, mag_a};
                        opb      <= mag_b;
                        is_div   <= md_div;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= md_div && (Rdata2 == 32'h0);
                        cnt      <= '0;
                    end else if (is_mthi) begin
                        hi <= Rdata1;
                    end else if (is_mtlo) begin
                        lo <= Rdata1;
                    end
                end
                BUSY: begin
                    acc <= step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        hi <= hi_fin;
                        lo <= lo_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Result = '0;
        case (op)
            OP_RTYPE: case (funct)
                F_SLL:         Result = Rdata2 << shamt;
                F_SRL:         Result = Rdata2 >> shamt;
                F_SRA:         Result = $signed(Rdata2) >>> shamt;
                F_MFHI:        Result = hi;
                F_MFLO:        Result = lo;
                F_ADD, F_ADDU: Result = Rdata1 + Rdata2;
                F_SUB, F_SUBU: Result = Rdata1 - Rdata2;
                F_AND:         Result = Rdata1 & Rdata2;
                F_OR:          Result = Rdata1 | Rdata2;
                F_XOR:         Result = Rdata1 ^ Rdata2;
                F_NOR:         Result = ~(Rdata1 | Rdata2);
                F_SLT:         Result = {31'h0, $signed(Rdata1) < $signed(Rdata2)};
                F_SLTU:        Result = {31'h0, Rdata1 < Rdata2};
                default:       Result = '0;
            endcase
            OP_ADDI, OP_ADDIU: Result = Rdata1 + Ed32;
            OP_SLTI:           Result = {31'h0, $signed(Rdata1) < $signed(Ed32)};
            OP_SLTIU:          Result = {31'h0, Rdata1 < Ed32};
            OP_ANDI:           Result = Rdata1 & zimm;
            OP_ORI:            Result = Rdata1 | zimm;
            OP_XORI:           Result = Rdata1 ^ zimm;
            OP_LUI:            Result = {Ins[15:0], 16'h0};
            OP_LW, OP_SW:      Result = Rdata1 + Ed32;
            default:           Result = '0;
        endcase
    end

endmodule
